// File: rtl/md5_collect_pkg.sv
// Shared types and helpers for the MD5 result collector.
// Digest width and flattened-bus slice arithmetic live here so top and bench agree.
package md5_collect_pkg;

    localparam int MD5_W = 128;

    typedef logic [MD5_W-1:0] md5_t;

    // LSB position of core idx's digest inside the flattened core_md5 bus.
    function automatic int unsigned md5_lsb(input int unsigned idx);
        return idx * MD5_W;
    endfunction

endpackage

// File: rtl/md5_collect_scan.sv
// Round-robin scan pointer over the core array.
// Wraps explicitly at CORE_COUNT-1 so non-power-of-2 arrays never see a phantom index.
module md5_collect_scan #(
    parameter  int CORE_COUNT = 1024,
    localparam int IDX_W      = $clog2(CORE_COUNT)
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [IDX_W-1:0] ptr_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(CORE_COUNT - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (enable_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ONE;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/md5_result_collector.sv
// Serializes finished digests from a core array onto one valid/ready stream.
// Each core is emitted once per run; clear starts a new run.
module md5_result_collector
    import md5_collect_pkg::*;
#(
    parameter  int CORE_COUNT = 1024,
    localparam int IDX_W      = $clog2(CORE_COUNT)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic [CORE_COUNT-1:0]       core_done,
    input  logic [CORE_COUNT*MD5_W-1:0] core_md5,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_index,
    output md5_t                        out_md5,
    output logic [IDX_W:0]              reported_count,
    output logic                        all_reported
);

    localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(CORE_COUNT);
    localparam logic [IDX_W:0] ONE  = (IDX_W + 1)'(1);

    // Stream handshake: a beat moves on every edge where out_valid && out_ready;
    // index/md5 hold while valid && !ready, and valid only falls after a transfer.
    logic [CORE_COUNT-1:0] reported_q, reported_d;
    logic                  valid_q, valid_d;
    logic [IDX_W-1:0]      index_q, index_d;
    md5_t                  md5_q, md5_d;
    logic [IDX_W:0]        count_q, count_d;
    logic                  all_q, all_d;

    logic [IDX_W-1:0] ptr;
    logic             loadable;
    logic             accept;
    logic             hit;

    assign accept   = valid_q && out_ready;
    assign loadable = !valid_q || out_ready;
    assign hit      = core_done[ptr] && !reported_q[ptr];

    md5_collect_scan #(
        .CORE_COUNT(CORE_COUNT)
    ) u_scan (
        .clock_i  (clock),
        .reset_n_i(reset_n),
        .clear_i  (clear),
        .enable_i (loadable),
        .ptr_o    (ptr)
    );

    always_comb begin
        reported_d = reported_q;
        valid_d    = valid_q;
        index_d    = index_q;
        md5_d      = md5_q;
        count_d    = count_q;
        if (clear) begin
            reported_d = '0;
            valid_d    = 1'b0;
            count_d    = '0;
        end else begin
            if (accept && (count_q != FULL)) begin
                count_d = count_q + ONE;
            end
            if (loadable) begin
                if (hit) begin
                    valid_d         = 1'b1;
                    index_d         = ptr;
                    md5_d           = core_md5[md5_lsb(int'(ptr)) +: MD5_W];
                    reported_d[ptr] = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
        end
        // Registered from the next count so it rises the cycle after the last transfer.
        all_d = (count_d == FULL);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reported_q <= '0;
            valid_q    <= 1'b0;
            index_q    <= '0;
            md5_q      <= '0;
            count_q    <= '0;
            all_q      <= 1'b0;
        end else begin
            reported_q <= reported_d;
            valid_q    <= valid_d;
            index_q    <= index_d;
            md5_q      <= md5_d;
            count_q    <= count_d;
            all_q      <= all_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_index      = index_q;
    assign out_md5        = md5_q;
    assign reported_count = count_q;
    assign all_reported   = all_q;

endmodule

// File: tb/tb_md5_result_collector.sv
// Directed bench for md5_result_collector with a 4-core and a 5-core instance.
module tb_md5_result_collector;

    logic           clock;
    logic           reset_n;
    logic           clear;
    logic           out_ready;

    logic [3:0]     done4;
    logic [4*128-1:0] md5_flat4;
    logic           valid4;
    logic [1:0]     index4;
    logic [127:0]   md5_4;
    logic [2:0]     count4;
    logic           all4;

    logic [4:0]     done5;
    logic [5*128-1:0] md5_flat5;
    logic           valid5;
    logic [2:0]     index5;
    logic [127:0]   md5_5;
    logic [3:0]     count5;
    logic           all5;

    int n_vec;
    int n_miss;

    md5_result_collector #(.CORE_COUNT(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .core_done(done4), .core_md5(md5_flat4),
        .out_valid(valid4), .out_ready(out_ready),
        .out_index(index4), .out_md5(md5_4),
        .reported_count(count4), .all_reported(all4)
    );

    md5_result_collector #(.CORE_COUNT(5)) dut5 (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .core_done(done5), .core_md5(md5_flat5),
        .out_valid(valid5), .out_ready(out_ready),
        .out_index(index5), .out_md5(md5_5),
        .reported_count(count5), .all_reported(all5)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [127:0] exp_md5(input int i);
        return {32'hDEAD_0000 + 32'(i), 32'h1234_5678 ^ 32'(i), 32'h0F0F_0F0F, 24'h00_0000, 8'hA4 + 8'(i)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a new run on both instances; afterwards both scan pointers sit at 0.
    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({valid4, index4, md5_4, count4, all4} !== '0) begin
            n_miss++;
            $display("FAIL reset4: v=%0b idx=%0d md5=%h cnt=%0d all=%0b, want all zero", valid4, index4, md5_4, count4, all4);
        end
        n_vec++;
        if ({valid5, index5, md5_5, count5, all5} !== '0) begin
            n_miss++;
            $display("FAIL reset5: v=%0b idx=%0d md5=%h cnt=%0d all=%0b, want all zero", valid5, index5, md5_5, count5, all5);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_two_cores();
        do_clear();
        done4 = 4'b0100;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        n_vec++;
        if (valid4 !== 1'b1 || index4 !== 2'd2 || md5_4 !== exp_md5(2) || count4 !== 3'd0) begin
            n_miss++;
            $display("FAIL two_cores_beat2: v=%0b idx=%0d md5=%h cnt=%0d, want 1/2/%h/0", valid4, index4, md5_4, count4, exp_md5(2));
        end
        done4 = 4'b0101;
        tick();
        n_vec++;
        if (valid4 !== 1'b0 || count4 !== 3'd1) begin
            n_miss++;
            $display("FAIL two_cores_gap: v=%0b cnt=%0d, want 0/1", valid4, count4);
        end
        tick();
        n_vec++;
        if (valid4 !== 1'b1 || index4 !== 2'd0 || md5_4 !== exp_md5(0)) begin
            n_miss++;
            $display("FAIL two_cores_beat0: v=%0b idx=%0d md5=%h, want 1/0/%h", valid4, index4, md5_4, exp_md5(0));
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_vec++;
            if (valid4 !== 1'b0) begin
                n_miss++;
                $display("FAIL two_cores_repeat: cycle %0d v=%0b idx=%0d, want no further beat", c, valid4, index4);
            end
        end
        n_vec++;
        if (count4 !== 3'd2 || all4 !== 1'b0) begin
            n_miss++;
            $display("FAIL two_cores_count: cnt=%0d all=%0b, want 2/0", count4, all4);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        done4 = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (valid4 !== 1'b1 || index4 !== 2'(k) || md5_4 !== exp_md5(k) || count4 !== 3'(k) || all4 !== 1'b0) begin
                n_miss++;
                $display("FAIL b2b_beat: k=%0d v=%0b idx=%0d cnt=%0d all=%0b md5=%h, want 1/%0d/%0d/0/%h", k, valid4, index4, count4, all4, md5_4, k, k, exp_md5(k));
            end
        end
        tick();
        n_vec++;
        if (valid4 !== 1'b0 || count4 !== 3'd4 || all4 !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_done: v=%0b cnt=%0d all=%0b, want 0/4/1", valid4, count4, all4);
        end
    endtask

    task automatic test_stall();
        do_clear();
        done4 = 4'b0010;
        out_ready = 1'b0;
        tick();
        tick();
        done4 = 4'b1010;
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (valid4 !== 1'b1 || index4 !== 2'd1 || md5_4 !== exp_md5(1) || count4 !== 3'd0) begin
                n_miss++;
                $display("FAIL stall_hold: cycle %0d v=%0b idx=%0d cnt=%0d md5=%h, want 1/1/0/%h", c, valid4, index4, count4, md5_4, exp_md5(1));
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (valid4 !== 1'b0 || count4 !== 3'd1) begin
            n_miss++;
            $display("FAIL stall_release: v=%0b cnt=%0d, want 0/1", valid4, count4);
        end
        tick();
        n_vec++;
        if (valid4 !== 1'b1 || index4 !== 2'd3 || count4 !== 3'd1) begin
            n_miss++;
            $display("FAIL stall_ptr_frozen: v=%0b idx=%0d cnt=%0d, want 1/3/1", valid4, index4, count4);
        end
        tick();
        n_vec++;
        if (valid4 !== 1'b0 || count4 !== 3'd2) begin
            n_miss++;
            $display("FAIL stall_after: v=%0b cnt=%0d, want 0/2", valid4, count4);
        end
        done4 = 4'b0000;
    endtask

    task automatic test_wrap5();
        do_clear();
        done5 = 5'b10000;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        n_vec++;
        if (valid5 !== 1'b1 || index5 !== 3'd4 || md5_5 !== exp_md5(14)) begin
            n_miss++;
            $display("FAIL wrap5_beat4: v=%0b idx=%0d md5=%h, want 1/4/%h", valid5, index5, md5_5, exp_md5(14));
        end
        done5 = 5'b10001;
        tick();
        n_vec++;
        if (valid5 !== 1'b1 || index5 !== 3'd0 || md5_5 !== exp_md5(10) || count5 !== 4'd1) begin
            n_miss++;
            $display("FAIL wrap5_beat0: v=%0b idx=%0d cnt=%0d md5=%h, want 1/0/1/%h", valid5, index5, count5, md5_5, exp_md5(10));
        end
        for (int c = 0; c < 15; c++) begin
            tick();
            n_vec++;
            if (valid5 !== 1'b0) begin
                n_miss++;
                $display("FAIL wrap5_extra: cycle %0d v=%0b idx=%0d, want no beat", c, valid5, index5);
            end
        end
        n_vec++;
        if (count5 !== 4'd2 || all5 !== 1'b0) begin
            n_miss++;
            $display("FAIL wrap5_count: cnt=%0d all=%0b, want 2/0", count5, all5);
        end
        done5 = 5'b00000;
    endtask

    task automatic test_clear();
        do_clear();
        done4 = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_vec++;
        if (valid4 !== 1'b0 || count4 !== 3'd0 || all4 !== 1'b0) begin
            n_miss++;
            $display("FAIL clear_flush: v=%0b cnt=%0d all=%0b, want 0/0/0", valid4, count4, all4);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (valid4 !== 1'b1 || index4 !== 2'(k) || md5_4 !== exp_md5(k)) begin
                n_miss++;
                $display("FAIL clear_reemit: k=%0d v=%0b idx=%0d md5=%h, want 1/%0d/%h", k, valid4, index4, md5_4, k, exp_md5(k));
            end
        end
        tick();
        n_vec++;
        if (count4 !== 3'd4 || all4 !== 1'b1) begin
            n_miss++;
            $display("FAIL clear_rerun: cnt=%0d all=%0b, want 4/1", count4, all4);
        end
    endtask

    task automatic test_async_reset();
        int waited;
        do_clear();
        done4 = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({valid4, index4, md5_4, count4, all4} !== '0) begin
            n_miss++;
            $display("FAIL async_reset: v=%0b idx=%0d md5=%h cnt=%0d all=%0b, want all zero", valid4, index4, md5_4, count4, all4);
        end
        tick();
        tick();
        reset_n = 1'b1;
        waited = 0;
        while (all4 !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_vec++;
        if (all4 !== 1'b1 || count4 !== 3'd4 || waited !== 5) begin
            n_miss++;
            $display("FAIL async_rerun: all=%0b cnt=%0d cycles=%0d, want 1/4/5", all4, count4, waited);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        clear     = 1'b0;
        out_ready = 1'b0;
        done4     = '0;
        done5     = '0;
        for (int i = 0; i < 4; i++) md5_flat4[128*i +: 128] = exp_md5(i);
        for (int i = 0; i < 5; i++) md5_flat5[128*i +: 128] = exp_md5(i + 10);

        test_reset();
        test_two_cores();
        test_back_to_back();
        test_stall();
        test_wrap5();
        test_clear();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
